// File: rtl/memory_driver_pkg.sv
// Shared definitions for the capture-memory driver: FSM state encoding and widths.
package memory_driver_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DONE    = 3'd2,
        ST_FULL    = 3'd3,
        ST_READ    = 3'd4
    } state_e;

endpackage

// File: rtl/memory_driver_ram.sv
// Single-write / single-read synchronous RAM with a one-cycle registered read port.
module memory_driver_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; the valid region is tracked by the driver's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/memory_driver_param.sv
// Capture-memory driver: stores a sample stream into a RAM at an auto-incrementing
// address, flags capacity and out-of-range samples, and streams the words back on request.
module memory_driver_param
    import memory_driver_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       DEPTH   = 64,
    parameter int unsigned       ADDR_W  = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               data_valid,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               stop_req,
    input  logic               rd_req,
    input  logic               clear,
    output logic [STATE_W-1:0] current_state,
    output logic               write,
    output logic [ADDR_W-1:0]  addr,
    output logic [ADDR_W:0]    count,
    output logic               memory_full,
    output logic               stop,
    output logic               range_err,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              write_q, write_d;
    logic              full_q, full_d;
    logic              stop_q, stop_d;
    logic              err_q, err_d;
    logic              rv_q, rv_d;
    logic              ram_we_c;
    logic              ram_re_c;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            write_q <= 1'b0;
            full_q  <= 1'b0;
            stop_q  <= 1'b1;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            write_q <= write_d;
            full_q  <= full_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
        end
    end

    // Next-state, counters, flags and RAM strobes; clear overrides every state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        write_d  = 1'b0;
        ram_we_c = 1'b0;
        ram_re_c = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_CAPTURE;
                        addr_d  = '0;
                        count_d = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (data_valid) begin
                        if (data_in > MAX_VAL) begin
                            err_d = 1'b1;
                        end else if (count_q != FULL_CNT) begin
                            ram_we_c = 1'b1;
                            write_d  = 1'b1;
                            addr_d   = addr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end
                    end
                    // A write that fills the RAM takes precedence over an early stop.
                    if (count_d == FULL_CNT) begin
                        state_d = ST_FULL;
                        addr_d  = '0;
                    end else if (stop_req) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE, ST_FULL: begin
                    if (rd_req && (count_q != '0)) begin
                        state_d = ST_READ;
                        addr_d  = '0;
                    end
                end
                ST_READ: begin
                    ram_re_c = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    if ({1'b0, addr_q} == (count_q - 1'b1)) begin
                        state_d = (count_q == FULL_CNT) ? ST_FULL : ST_DONE;
                        addr_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rv_d   = (state_q == ST_READ) && !clear;
        full_d = (count_d == FULL_CNT);
        stop_d = full_d || (state_d != ST_CAPTURE);
    end

    memory_driver_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we_c),
        .waddr   (addr_q),
        .wdata   (data_in),
        .re      (ram_re_c),
        .raddr   (addr_q),
        .rd_data (rd_data)
    );

    assign current_state = state_q;
    assign write         = write_q;
    assign addr          = addr_q;
    assign count         = count_q;
    assign memory_full   = full_q;
    assign stop          = stop_q;
    assign range_err     = err_q;
    assign rd_valid      = rv_q;

endmodule

// File: tb/tb_memory_driver_param.sv
// Bench for memory_driver_param: a 32x64 and a 16x8 instance share stimulus and are
// checked every cycle against a behavioural model of the capture/readback rules.
module tb_memory_driver_param;

    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_DONE = 2;
    localparam int M_FULL = 3;
    localparam int M_READ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, data_valid = 1'b0, stop_req = 1'b0, rd_req = 1'b0, clear = 1'b0;
    logic [31:0] din = '0;

    logic [2:0]  a_state;  logic a_write;  logic [5:0] a_addr;  logic [6:0] a_count;
    logic        a_full, a_stop, a_err, a_rv;  logic [31:0] a_rd;
    logic [2:0]  b_state;  logic b_write;  logic [2:0] b_addr;  logic [3:0] b_count;
    logic        b_full, b_stop, b_err, b_rv;  logic [15:0] b_rd;

    int total = 0;
    int bad   = 0;
    int rv_seen = 0;
    int wr_seen = 0;

    // Model: per instance (0 = 32x64, 1 = 16x8)
    logic [31:0] mmem [2][64];
    int          m_mode [2];
    int          m_cnt  [2];
    int          m_ptr  [2];
    bit          m_err  [2];
    bit          m_wr   [2];
    bit          m_rv   [2];
    logic [31:0] m_rd   [2];

    always #5 clk = ~clk;

    memory_driver_param u_a (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .data_in(din),
        .stop_req(stop_req), .rd_req(rd_req), .clear(clear),
        .current_state(a_state), .write(a_write), .addr(a_addr), .count(a_count),
        .memory_full(a_full), .stop(a_stop), .range_err(a_err),
        .rd_data(a_rd), .rd_valid(a_rv)
    );

    memory_driver_param #(.DATA_W(16), .DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .data_in(din[15:0]),
        .stop_req(stop_req), .rd_req(rd_req), .clear(clear),
        .current_state(b_state), .write(b_write), .addr(b_addr), .count(b_count),
        .memory_full(b_full), .stop(b_stop), .range_err(b_err),
        .rd_data(b_rd), .rd_valid(b_rv)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 64 : 8;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k] = M_IDLE; m_cnt[k] = 0; m_ptr[k] = 0;
        m_err[k] = 0; m_wr[k] = 0; m_rv[k] = 0; m_rd[k] = '0;
    endtask

    task automatic model_step(input int k);
        int          d;
        logic [31:0] v, mx;
        bit          last;
        d  = dep(k);
        mx = (k == 0) ? 32'h7FFF_FFFF : 32'h0000_7FFF;
        v  = (k == 0) ? din : {16'h0, din[15:0]};
        m_wr[k] = 0;
        m_rv[k] = 0;
        if (clear) begin
            m_mode[k] = M_IDLE; m_cnt[k] = 0; m_ptr[k] = 0; m_err[k] = 0;
        end else begin
            case (m_mode[k])
                M_IDLE: if (start) begin
                    m_mode[k] = M_CAP; m_cnt[k] = 0; m_ptr[k] = 0; m_err[k] = 0;
                end
                M_CAP: begin
                    if (data_valid && v <= mx) begin
                        mmem[k][m_ptr[k]] = v;
                        m_wr[k]  = 1;
                        m_ptr[k] = (m_ptr[k] + 1) % d;
                        m_cnt[k] = m_cnt[k] + 1;
                    end else if (data_valid) begin
                        m_err[k] = 1;
                    end
                    if (m_cnt[k] == d)  m_mode[k] = M_FULL;
                    else if (stop_req)  m_mode[k] = M_DONE;
                end
                M_DONE, M_FULL: if (rd_req && m_cnt[k] > 0) begin
                    m_mode[k] = M_READ; m_ptr[k] = 0;
                end
                default: begin
                    m_rd[k]  = mmem[k][m_ptr[k]];
                    m_rv[k]  = 1;
                    last     = (m_ptr[k] == m_cnt[k] - 1);
                    m_ptr[k] = m_ptr[k] + 1;
                    if (last) begin
                        m_mode[k] = (m_cnt[k] == d) ? M_FULL : M_DONE;
                        m_ptr[k]  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("a_state", 64'(a_state), 64'(m_mode[0]));
        check("a_write", 64'(a_write), 64'(m_wr[0]));
        check("a_addr",  64'(a_addr),  64'(m_ptr[0]));
        check("a_count", 64'(a_count), 64'(m_cnt[0]));
        check("a_full",  64'(a_full),  64'(m_cnt[0] == 64));
        check("a_stop",  64'(a_stop),  64'(m_cnt[0] == 64 || m_mode[0] != M_CAP));
        check("a_err",   64'(a_err),   64'(m_err[0]));
        check("a_rv",    64'(a_rv),    64'(m_rv[0]));
        if (m_rv[0]) check("a_rd", 64'(a_rd), 64'(m_rd[0]));
        check("b_state", 64'(b_state), 64'(m_mode[1]));
        check("b_write", 64'(b_write), 64'(m_wr[1]));
        check("b_addr",  64'(b_addr),  64'(m_ptr[1]));
        check("b_count", 64'(b_count), 64'(m_cnt[1]));
        check("b_full",  64'(b_full),  64'(m_cnt[1] == 8));
        check("b_stop",  64'(b_stop),  64'(m_cnt[1] == 8 || m_mode[1] != M_CAP));
        check("b_err",   64'(b_err),   64'(m_err[1]));
        check("b_rv",    64'(b_rv),    64'(m_rv[1]));
        if (m_rv[1]) check("b_rd", 64'(b_rd), 64'(m_rd[1][15:0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) model_reset(k);
            else      model_step(k);
        end
        #1;
        compare_all();
        if (a_rv)    rv_seen++;
        if (a_write) wr_seen++;
    endtask

    task automatic drive(input bit s, input bit dv, input logic [31:0] d,
                         input bit sr, input bit rr, input bit cl);
        start = s; data_valid = dv; din = d; stop_req = sr; rd_req = rr; clear = cl;
        cycle();
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(a_state), 64'd0);
        check("rst_addr",  64'(a_addr),  64'd0);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_full",  64'(a_full),  64'd0);
        check("rst_write", 64'(a_write), 64'd0);
        check("rst_err",   64'(a_err),   64'd0);
        check("rst_rv",    64'(a_rv),    64'd0);
        check("rst_rd",    64'(a_rd),    64'd0);
        check("rst_b_cnt", 64'(b_count), 64'd0);
        rst = 1'b1;

        // Fill with 1..64; the small instance saturates after 8
        drive(1, 0, 0, 0, 0, 0);
        wr_seen = 0;
        for (int i = 1; i <= 64; i++) drive(0, 1, 32'(i), 0, 0, 0);
        check("fill_writes", 64'(wr_seen), 64'd64);
        check("fill_count",  64'(a_count), 64'd64);
        check("fill_full",   64'(a_full),  64'd1);
        check("fill_stop",   64'(a_stop),  64'd1);
        check("fill_state",  64'(a_state), 64'd3);
        check("fill_b_cnt",  64'(b_count), 64'd8);

        // Full readback: 64 contiguous words, then back in FULL at addr 0
        drive(0, 0, 0, 0, 1, 0);
        rv_seen = 0;
        repeat (64) drive(0, 0, 0, 0, 0, 0);
        check("rb64_words", 64'(rv_seen), 64'd64);
        drive(0, 0, 0, 0, 0, 0);
        check("rb64_rv_end", 64'(a_rv),    64'd0);
        check("rb64_state",  64'(a_state), 64'd3);
        check("rb64_addr",   64'(a_addr),  64'd0);

        // Out-of-range sample for both widths; error is sticky
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h8000_8000, 0, 0, 0);
        check("rng_err",   64'(a_err),   64'd1);
        check("rng_count", 64'(a_count), 64'd0);
        check("rng_write", 64'(a_write), 64'd0);
        check("rng_b_err", 64'(b_err),   64'd1);
        drive(0, 1, 32'h0000_0005, 0, 0, 0);
        check("rng_sticky", 64'(a_err),  64'd1);

        // Three samples, early stop, readback of 1,2,3
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(0, 1, 32'(i), 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("stop3_state", 64'(a_state), 64'd2);
        check("stop3_count", 64'(a_count), 64'd3);
        drive(0, 0, 0, 0, 1, 0);
        rv_seen = 0;
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        check("stop3_words", 64'(rv_seen), 64'd3);
        check("stop3_done",  64'(a_state), 64'd2);

        // rd_req with nothing captured stays in DONE
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("empty_rd_state", 64'(a_state), 64'd2);
        check("empty_rd_rv",    64'(a_rv),    64'd0);

        // Clear in the middle of a burst
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) drive(0, 1, $urandom & 32'h7FFF_7FFF, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        repeat (10) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("clr_state", 64'(a_state), 64'd0);
        check("clr_rv",    64'(a_rv),    64'd0);
        check("clr_count", 64'(a_count), 64'd0);

        // Asynchronous reset in the middle of a capture
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 32'(i + 100), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("arst_state", 64'(a_state), 64'd0);
        check("arst_count", 64'(a_count), 64'd0);
        check("arst_addr",  64'(a_addr),  64'd0);
        compare_all();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 7) != 0) r = r & 32'h7FFF_7FFF;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, r,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
